dmem_subword_ctrl: RTL and testbench
====================================

Name: dmem_subword_ctrl

Overview:
Parametrised data memory for the RV32I core. Supports byte, halfword and word loads and stores with RISC-V funct3 encoding, and returns registered read data on a req/ready/rvalid handshake. After reset it clears itself word by word through a small state machine. Misaligned or illegal accesses are flagged, and the memory is never corrupted by them. It sits between the execute stage and the FPGA display path.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
IDX_W, $clog2(DEPTH_WORDS), word-index width; derived, never overridden.
SEL_W, 10, width of the display select input.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
req  in  1  access request
we  in  1  1 = store, 0 = load; sampled with req
funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  byte address
wdata  in  32  store data; B uses [7:0], H uses [15:0]
ready  out  1  block can accept a request this cycle
rdata  out  32  load result, valid while rvalid=1
rvalid  out  1  one-cycle response strobe, for loads and for errors
err  out  1  qualifies rvalid: misaligned or illegal access
init_busy  out  1  clear sweep in progress
sw  in  SEL_W  display word select
hex_led_data  out  32  display word

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to CLEAR and clr_idx goes to 0.
  - ready=0, rvalid=0, err=0, rdata=0, init_busy=1, hex_led_data=0.
- CLEAR state:
  - Writes 0 to mem[clr_idx] each cycle and increments clr_idx.
  - After writing DEPTH_WORDS-1, moves to IDLE. The sweep takes DEPTH_WORDS cycles.
  - init_busy=1 and ready=0 throughout; req is ignored.
- Reset mid-sweep restarts the sweep at index 0.
- Reset in IDLE drops any in-flight response; rvalid=0 next cycle.
- IDLE state: ready=1 and init_busy=0. A request is accepted when req && ready at a rising edge.
- Index is addr[IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Alignment:
  - H/HU require addr[0]=0.
  - W requires addr[1:0]=0.
  - B/BU are always aligned.
- Illegal accesses:
  - funct3 011, 110 or 111.
  - A store with funct3 100 or 101.
- Accepted store, legal and aligned:
  - Byte lanes are written on the accepting edge.
  - Lane mask: B = 1 << addr[1:0]; H = 0011 or 1100 selected by addr[1]; W = 1111.
  - Data is replicated onto the selected lanes. Unselected lanes are unchanged.
  - No rvalid is produced.
- Accepted load, legal and aligned:
  - On the next cycle, rvalid=1, err=0, and rdata is the extracted lane.
  - B/H results are sign-extended; BU/HU results are zero-extended.
  - Latency is 1 cycle.
- Misaligned or illegal access:
  - No memory write.
  - Next cycle: rvalid=1, err=1, rdata=0. This applies to stores as well.
- rvalid/err fall to 0 on any cycle without a new qualifying response.
- Back-to-back accepts are allowed: one per cycle, full throughput.
- A load in cycle N+1 to the word stored in cycle N returns the new data.
- The block never stalls after CLEAR completes; ready stays 1 until the next reset.

Optional Feature:
DMEM_DISPLAY_EN
- Defined:
  - hex_led_data is registered: it takes mem[sw[IDX_W-1:0]] one cycle after sw changes.
  - If SEL_W > IDX_W, the upper sw bits are ignored.
  - The display path reflects a store one cycle after the store's write edge.
  - hex_led_data resets to 0.
- Undefined: hex_led_data is tied to 0, sw is unused, and no read port is inferred for the display.

Test Plan:
- Release rst_n after writing 0xDEADBEEF to word 5 in a previous run -> init_busy=1 and ready=0 for exactly 1024 cycles; then LW addr 0x14 gives rdata=0x00000000, rvalid=1, err=0.
- SW 0x11223344 @0x100, then LB @0x103, LBU @0x103, LH @0x102, LHU @0x100 -> 0x00000011, 0x00000011, 0x00001122, 0x00003344.
- SW 0x000000F0 @0x200, SB 0x80 @0x201, LB @0x201 then LH @0x200 -> 0xFFFFFF80, 0xFFFF80F0.
- LW @0x102, SH 0xBEEF @0x103, load with funct3=011 -> each gives rvalid=1, err=1, rdata=0; a following LW @0x100 still returns 0x11223344.
- Assert rst_n=0 for one cycle at sweep index 500 -> sweep restarts and ready rises 1024 cycles after release; SW @0x1004 (wraps to word 1) then LW @0x4 -> returns the stored value.
- With DMEM_DISPLAY_EN: store 0xCAFEF00D to word 7 and set sw=7 -> hex_led_data=0xCAFEF00D one cycle later. Without the macro -> hex_led_data=0 always.

Source files
------------

// File: rtl/dmem_subword_ctrl_if.sv
// Request/response bus between the execute stage and the data memory.
// master drives requests, slave returns ready and the load/error response.
interface dmem_subword_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    modport master (
        output req, we, funct3, addr, wdata,
        input  ready, rdata, rvalid, err
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output ready, rdata, rvalid, err
    );
endinterface

// File: rtl/dmem_subword_ctrl.sv
// RV32I data memory with byte/half/word access, post-reset clear sweep and fault flagging.
// Optional registered display read port is enabled by defining DMEM_DISPLAY_EN.
module dmem_subword_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS),
    parameter int SEL_W       = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    dmem_subword_ctrl_if.slave   bus,
    input  logic [SEL_W-1:0]     i_sw,
    output logic                 o_init_busy,
    output logic [31:0]          o_hex_led_data
);
    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_clr_idx;
    logic [3:0][7:0]  r_mem [DEPTH_WORDS];

    logic             w_ready, w_busy;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_off;
    logic [2:0]       w_f3;
    logic             w_illegal, w_misal, w_fault;
    logic             w_accept, w_st, w_ld, w_clr_we;
    logic [3:0]       w_mask;
    logic [3:0][7:0]  w_wdat;
    logic [3:0][7:0]  w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ld_data;

    logic             r_rvalid, r_err;
    logic [31:0]      r_rdata;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR)
                r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_busy = 1'b1;
                if (r_clr_idx == IDX_W'(DEPTH_WORDS - 1))
                    w_state_nxt = S_IDLE;
            end
            default: w_ready = 1'b1;
        endcase
    end

    assign w_idx = bus.addr[IDX_W+1:2];
    assign w_off = bus.addr[1:0];
    assign w_f3  = bus.funct3;

    // Unsigned widths only exist for loads; 011/11x are not memory ops at all.
    assign w_illegal = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11) || (bus.we && w_f3[2]);
    assign w_misal   = ((w_f3[1:0] == 2'b01) && w_off[0]) ||
                       ((w_f3[1:0] == 2'b10) && (w_off != 2'b00));
    assign w_fault   = w_illegal || w_misal;

    assign w_accept = bus.req && w_ready && i_rst_n;
    assign w_st     = w_accept && bus.we && !w_fault;
    assign w_ld     = w_accept && !bus.we && !w_fault;
    assign w_clr_we = i_rst_n && (r_state == S_CLEAR);

    always_comb begin
        w_mask = 4'b0000;
        w_wdat = bus.wdata;
        case (w_f3[1:0])
            2'b00: begin
                w_mask = 4'b0001 << w_off;
                w_wdat = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                w_mask = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{bus.wdata[15:0]}};
            end
            2'b10:   w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_clr_we)
            r_mem[r_clr_idx] <= '0;
        else if (w_st)
            for (int l = 0; l < 4; l++)
                if (w_mask[l])
                    r_mem[w_idx][l] <= w_wdat[l];
    end

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[w_off];
    assign w_half = w_off[1] ? w_word[3:2] : w_word[1:0];

    always_comb begin
        w_ld_data = '0;
        case (w_f3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'h0, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'h0, w_half};
            3'b010:  w_ld_data = w_word;
            default: w_ld_data = '0;
        endcase
    end

    // Faults answer with a zero payload so a consumer ignoring err never sees stale data.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_ld || (w_accept && w_fault);
            r_err    <= w_accept && w_fault;
            if (w_accept && w_fault)
                r_rdata <= '0;
            else if (w_ld)
                r_rdata <= w_ld_data;
        end
    end

    assign bus.ready   = w_ready;
    assign bus.rvalid  = r_rvalid;
    assign bus.err     = r_err;
    assign bus.rdata   = r_rdata;
    assign o_init_busy = w_busy;

`ifdef DMEM_DISPLAY_EN
    logic [IDX_W-1:0] w_sel;
    logic [31:0]      r_hex;
    logic             w_unused;

    assign w_sel = IDX_W'(i_sw);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_hex <= '0;
        else
            r_hex <= r_mem[w_sel];
    end

    assign o_hex_led_data = r_hex;
    assign w_unused       = ^{i_sw, bus.addr[31:IDX_W+2]};
`else
    logic w_unused;

    assign o_hex_led_data = '0;
    assign w_unused       = ^{i_sw, bus.addr[31:IDX_W+2]};
`endif
endmodule

// File: tb/tb_dmem_subword_ctrl.sv
// Bench for dmem_subword_ctrl: directed scenarios plus random traffic against a byte-array model.
module tb_dmem_subword_ctrl;
    localparam int DEPTH  = 1024;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  sw = '0;
    logic        init_busy;
    logic [31:0] hex;
    logic [31:0] got;

    logic [7:0]  mref [NBYTES];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    dmem_subword_ctrl_if bus();

    dmem_subword_ctrl #(.DEPTH_WORDS(DEPTH), .SEL_W(10)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .bus            (bus.slave),
        .i_sw           (sw),
        .o_init_busy    (init_busy),
        .o_hex_led_data (hex)
    );

    function automatic bit m_bad(bit we, logic [2:0] f3, logic [31:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (we && (f3 == 3'b100 || f3 == 3'b101)) return 1'b1;
        if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 1'b1;
        if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_size(logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic void m_store(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        int unsigned b;
        b = a % NBYTES;
        for (int k = 0; k < m_size(f3); k++) mref[b + k] = wd[8*k +: 8];
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a);
        int unsigned b;
        int          n;
        logic [31:0] v;
        b = a % NBYTES;
        n = m_size(f3);
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mref[b + k];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input string nm);
        bit          eb, ev;
        logic [31:0] ed;
        @(negedge clk);
        total++;
        if (bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready act=%b exp=1", nm, bus.ready);
        end
        bus.req = 1'b1; bus.we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        eb = m_bad(we, f3, a);
        ev = eb || !we;
        ed = '0;
        if (!eb) begin
            if (we) m_store(f3, a, wd);
            else    ed = m_load(f3, a);
        end
        @(posedge clk); #1;
        got = bus.rdata;
        total++;
        if (bus.rvalid !== ev || bus.err !== eb || (ev && bus.rdata !== ed)) begin
            bad++;
            $display("FAIL %s rvalid/err/rdata act=%b/%b/%h exp=%b/%b/%h",
                     nm, bus.rvalid, bus.err, bus.rdata, ev, eb, ed);
        end
    endtask

    task automatic idle(input string nm);
        @(negedge clk);
        bus.req = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.rvalid !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL %s idle rvalid/err act=%b/%b exp=0/0", nm, bus.rvalid, bus.err);
        end
    endtask

    task automatic sweep_wait(input string nm);
        int n;
        bit ok;
        n = 0;
        ok = 1'b1;
        while (init_busy === 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (bus.ready !== ~init_busy) ok = 1'b0;
        end
        total++;
        if (n != DEPTH) begin
            bad++;
            $display("FAIL %s sweep cycles act=%0d exp=%0d", nm, n, DEPTH);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s ready/init_busy not complementary during sweep act=0 exp=1", nm);
        end
        for (int i = 0; i < NBYTES; i++) mref[i] = 8'h00;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.ready !== 1'b0 || bus.rvalid !== 1'b0 || bus.err !== 1'b0 ||
            bus.rdata !== 32'h0 || init_busy !== 1'b1 || hex !== 32'h0) begin
            bad++;
            $display("FAIL %s reset rdy/rv/err/rdata/busy/hex act=%b/%b/%b/%h/%b/%h exp=0/0/0/0/1/0",
                     nm, bus.ready, bus.rvalid, bus.err, bus.rdata, init_busy, hex);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.req = 1'b0;
        sweep_wait(nm);
    endtask

    task automatic test_reset();
        do_reset("reset0");
        op(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, "sw_dead");
        op(1'b0, 3'b010, 32'h14, 32'h0, "lw_dead");
        total++;
        if (got !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL lw_dead_const act=%h exp=deadbeef", got);
        end
        // load request still asserted on the reset edge must not produce a response
        do_reset("reset1");
        op(1'b0, 3'b010, 32'h14, 32'h0, "lw_cleared");
        total++;
        if (got !== 32'h0) begin
            bad++;
            $display("FAIL lw_cleared_const act=%h exp=00000000", got);
        end
        idle("reset_idle");
    endtask

    task automatic test_subword();
        logic [31:0] exp_v [4];
        logic [2:0]  f3s   [4];
        logic [31:0] as    [4];
        exp_v = '{32'h11, 32'h11, 32'h1122, 32'h3344};
        f3s   = '{3'b000, 3'b100, 3'b001, 3'b101};
        as    = '{32'h103, 32'h103, 32'h102, 32'h100};
        op(1'b1, 3'b010, 32'h100, 32'h11223344, "sw_100");
        for (int i = 0; i < 4; i++) begin
            op(1'b0, f3s[i], as[i], 32'h0, "ld_sub");
            total++;
            if (got !== exp_v[i]) begin
                bad++;
                $display("FAIL ld_sub_const[%0d] act=%h exp=%h", i, got, exp_v[i]);
            end
        end
        op(1'b1, 3'b010, 32'h200, 32'h000000F0, "sw_200");
        op(1'b1, 3'b000, 32'h201, 32'h00000080, "sb_201");
        op(1'b0, 3'b000, 32'h201, 32'h0, "lb_201");
        total++;
        if (got !== 32'hFFFFFF80) begin
            bad++;
            $display("FAIL lb_201_const act=%h exp=ffffff80", got);
        end
        op(1'b0, 3'b001, 32'h200, 32'h0, "lh_200");
        total++;
        if (got !== 32'hFFFF80F0) begin
            bad++;
            $display("FAIL lh_200_const act=%h exp=ffff80f0", got);
        end
        idle("subword_idle");
    endtask

    task automatic test_errors();
        op(1'b0, 3'b010, 32'h102, 32'h0, "lw_misal");
        op(1'b1, 3'b001, 32'h103, 32'hBEEF, "sh_misal");
        op(1'b0, 3'b011, 32'h100, 32'h0, "ld_f3_011");
        op(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF, "st_f3_100");
        op(1'b1, 3'b111, 32'h100, 32'hFFFFFFFF, "st_f3_111");
        op(1'b0, 3'b010, 32'h100, 32'h0, "lw_after_err");
        total++;
        if (got !== 32'h11223344) begin
            bad++;
            $display("FAIL lw_after_err_const act=%h exp=11223344", got);
        end
        idle("err_idle");
    endtask

    task automatic test_back_to_back();
        op(1'b1, 3'b010, 32'h40, 32'hA5A55A5A, "b2b_sw");
        op(1'b0, 3'b010, 32'h40, 32'h0, "b2b_lw");
        op(1'b1, 3'b001, 32'h42, 32'h00001234, "b2b_sh");
        op(1'b0, 3'b101, 32'h42, 32'h0, "b2b_lhu");
        op(1'b0, 3'b010, 32'h40, 32'h0, "b2b_lw2");
        total++;
        if (got !== 32'h12345A5A) begin
            bad++;
            $display("FAIL b2b_const act=%h exp=12345a5a", got);
        end
        idle("b2b_idle");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (500) @(posedge clk);
        do_reset("reset_mid");
        op(1'b1, 3'b010, 32'h1004, 32'h5EEDF00D, "sw_wrap");
        op(1'b0, 3'b010, 32'h4, 32'h0, "lw_wrap");
        total++;
        if (got !== 32'h5EEDF00D) begin
            bad++;
            $display("FAIL lw_wrap_const act=%h exp=5eedf00d", got);
        end
        idle("mid_idle");
    endtask

    task automatic test_random();
        logic [31:0] a, wd;
        logic [2:0]  f3;
        bit          we;
        for (int i = 0; i < 400; i++) begin
            a  = $urandom() & 32'hFFFF_F03F;
            wd = $urandom();
            f3 = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            op(we, f3, a, wd, "rand");
            if ($urandom_range(0, 7) == 0) idle("rand_idle");
        end
        idle("rand_end");
    endtask

    task automatic test_display();
`ifdef DMEM_DISPLAY_EN
        op(1'b1, 3'b010, 32'h1C, 32'hCAFEF00D, "sw_disp");
        idle("disp_idle");
        @(negedge clk);
        sw = 10'd7;
        @(posedge clk); #1;
        total++;
        if (hex !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL display act=%h exp=cafef00d", hex);
        end
        op(1'b1, 3'b000, 32'h1C, 32'h00000011, "sb_disp");
        @(posedge clk); #1;
        total++;
        if (hex !== 32'hCAFEF011) begin
            bad++;
            $display("FAIL display_update act=%h exp=cafef011", hex);
        end
        idle("disp_idle2");
`else
        op(1'b1, 3'b010, 32'h1C, 32'hCAFEF00D, "sw_disp");
        idle("disp_idle");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sw = 10'(7 + i);
            @(posedge clk); #1;
            total++;
            if (hex !== 32'h0) begin
                bad++;
                $display("FAIL display_off act=%h exp=00000000", hex);
            end
        end
`endif
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000;
        bus.addr = '0; bus.wdata = '0;
        test_reset();
        test_subword();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_display();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
